// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default constants for the UART transmit queue
package uart_pkg;

    localparam int UART_DW               = 8;
    localparam int UART_TXQ_DEPTH        = 8;
    // Cycles the launcher waits for tx_busy to rise before assuming the frame is gone
    localparam int UART_TXQ_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } txq_state_t;

endpackage

// File: rtl/uart_txq_mem.sv
// rtl/uart_txq_mem.sv - DEPTH x DW queue storage, one write port, read from a registered pointer
module uart_txq_mem #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Contents carry no reset; only the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_addr is the owner's read pointer register, so the head is always presented
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding a UART transmitter via a one-frame-at-a-time launcher; UART_TXQ_OVF_EN enables the sticky overflow flag
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEPTH,
    parameter int DW    = UART_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DW-1:0]            data_in,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [1:0]    TIMEOUT_C = 2'(UART_TXQ_BUSY_TIMEOUT - 1);

    txq_state_t     state;
    logic [1:0]     busy_cnt;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_nxt;
    logic [DW-1:0]  rd_data;
    logic           pop;
    logic           push_ok;

    // Pop only from IDLE with a byte waiting and the line free; a full queue still
    // accepts a push on the cycle it pops because the freed slot is the one written
    assign pop     = (state == ST_IDLE) && !empty && !tx_busy;
    assign push_ok = wr_en && (!full || pop);

    uart_txq_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers and registered occupancy flags, all derived from the same next count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == DEPTH_C);
        end
    end

    // Launcher: one byte per transmitter frame, with a bounded wait for tx_busy to rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            data_in  <= '0;
            busy_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_LAUNCH;
                        tx_start <= 1'b1;
                        data_in  <= rd_data;
                    end
                end
                ST_LAUNCH: begin
                    state    <= ST_WAIT_BUSY;
                    busy_cnt <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy || (busy_cnt == TIMEOUT_C)) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_q;

    // Sticky flag for pushes lost to a full queue; a new loss outranks a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full && !pop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue with a queue-level reference model
module tb_uart_tx_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef UART_TXQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] data_in;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    logic hold_busy  = 1'b0;
    logic frame_busy = 1'b0;
    logic frame_en   = 1'b1;
    int   frame_len  = 100;
    int   frame_left = 0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    logic [DW-1:0] launched[$];
    int            launch_cyc[$];

    // reference model state
    logic [DW-1:0] m_q[$];
    logic          m_start = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_ovf   = 1'b0;
    logic          m_claim = 1'b0;
    logic          m_done_wait = 1'b0;
    int            m_age = 0;

    assign tx_busy = hold_busy | frame_busy;

    uart_tx_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .data_in  (data_in),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // transmitter: busy for frame_len cycles after each observed launch
    always @(negedge clk) begin
        if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) frame_busy = 1'b0;
        end else if (frame_en && reset && tx_start) begin
            frame_busy = 1'b1;
            frame_left = frame_len;
        end
    end

    // log every launch with its byte and cycle
    always @(negedge clk) begin
        if (reset && tx_start) begin
            launched.push_back(data_in);
            launch_cyc.push_back(cyc);
        end
    end

    // reference model: a byte queue plus a launcher that holds the line per frame
    always @(posedge clk) begin
        logic pop;
        logic room;
        if (!reset) begin
            m_q.delete();
            m_start = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_claim = 1'b0;
            m_done_wait = 1'b0;
            m_age   = 0;
        end else begin
            pop  = !m_claim && (m_q.size() > 0) && !tx_busy;
            room = (m_q.size() < DEPTH) || pop;
            if (m_claim) begin
                m_age++;
                if (m_age >= 2) begin
                    if (!m_done_wait) begin
                        if (tx_busy || m_age == 5) m_done_wait = 1'b1;
                    end else if (!tx_busy) begin
                        m_claim = 1'b0;
                    end
                end
            end
            m_start = pop;
            if (pop) begin
                m_data      = m_q.pop_front();
                m_claim     = 1'b1;
                m_age       = 0;
                m_done_wait = 1'b0;
            end
            if (wr_en && room) m_q.push_back(wr_data);
            if (OVF_EN) begin
                if (wr_en && !room) m_ovf = 1'b1;
                else if (ovf_clr)   m_ovf = 1'b0;
            end
        end
    end

    // per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic [15:0] exp_v;
        logic [15:0] act_v;
        if (chk_en) begin
            if (!reset) begin
                exp_v = {4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
            end else begin
                exp_v = {4'(m_q.size()), (m_q.size() == DEPTH), (m_q.size() == 0),
                         m_start, m_data, m_ovf};
            end
            act_v = {count, full, empty, tx_start, data_in, ovf};
            check("cycle {count,full,empty,tx_start,data_in,ovf}", 32'(act_v), 32'(exp_v));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget);
        int k;
        k = 0;
        while (launched.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("launch_count", 32'(launched.size()), 32'(n));
    endtask

    initial begin
        int b;
        logic [DW-1:0] exp_order[9];

        // reset state
        tick(2);
        chk_en = 1'b1;
        tick(1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
        tick(2);

        // single byte into idle queue: launch two cycles after the push
        push(8'hA5);
        check("t1_count_after_push", 32'(count), 32'd1);
        check("t1_no_early_start", 32'(tx_start), 32'd0);
        tick(1);
        check("t1_tx_start", 32'(tx_start), 32'd1);
        check("t1_data_in", 32'(data_in), 32'hA5);
        check("t1_count_after_pop", 32'(count), 32'd0);
        tick(1);
        check("t1_start_one_cycle", 32'(tx_start), 32'd0);
        tick(110);

        // three bytes, 100-cycle frames: launches 102 cycles apart, in order
        b = launched.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_launches(b + 3, 400);
        tick(110);
        if (launched.size() >= b + 3) begin
            check("t2_byte0", 32'(launched[b]), 32'h11);
            check("t2_byte1", 32'(launched[b+1]), 32'h22);
            check("t2_byte2", 32'(launched[b+2]), 32'h33);
            check("t2_gap01", 32'(launch_cyc[b+1] - launch_cyc[b]), 32'd102);
            check("t2_gap12", 32'(launch_cyc[b+2] - launch_cyc[b+1]), 32'd102);
        end

        // fill with the line held busy, then overflow
        hold_busy = 1'b1;
        tick(1);
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd8);
        push(8'hEE);
        check("t3_count_after_drop", 32'(count), 32'd8);
        check("t3_ovf_set", 32'(ovf), 32'(OVF_EN));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(ovf), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'hEF;
        ovf_clr = 1'b1;
        tick(1);
        wr_en   = 1'b0;
        check("t3_set_beats_clr", 32'(ovf), 32'(OVF_EN));
        tick(1);
        ovf_clr = 1'b0;
        check("t3_ovf_clr2", 32'(ovf), 32'd0);

        // full queue: push and pop in the same cycle
        frame_len = 10;
        b = launched.size();
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h99;
        tick(1);
        wr_en     = 1'b0;
        check("t4_count_stays", 32'(count), 32'd8);
        check("t4_full_stays", 32'(full), 32'd1);
        check("t4_tx_start", 32'(tx_start), 32'd1);
        check("t4_head", 32'(data_in), 32'h40);
        wait_launches(b + 9, 400);
        for (int i = 0; i < 8; i++) exp_order[i] = 8'h40 + 8'(i);
        exp_order[8] = 8'h99;
        if (launched.size() >= b + 9) begin
            for (int i = 0; i < 9; i++) check("t4_order", 32'(launched[b+i]), 32'(exp_order[i]));
        end
        tick(20);

        // reset during a frame with three bytes still queued
        frame_len = 50;
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        push(8'hA4);
        tick(10);
        check("t5_count_before_rst", 32'(count), 32'd3);
        reset = 1'b0;
        tick(2);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_tx_start", 32'(tx_start), 32'd0);
        reset = 1'b1;
        b = launched.size();
        tick(100);
        check("t5_no_launch_after_rst", 32'(launched.size()), 32'(b));
        push(8'h5C);
        wait_launches(b + 1, 200);
        if (launched.size() >= b + 1) check("t5_new_byte", 32'(launched[b]), 32'h5C);
        tick(60);

        // transmitter never goes busy: timeout path, next launch 7 cycles later
        frame_en = 1'b0;
        b = launched.size();
        push(8'hB1);
        push(8'hB2);
        wait_launches(b + 2, 60);
        if (launched.size() >= b + 2) begin
            check("t6_byte0", 32'(launched[b]), 32'hB1);
            check("t6_byte1", 32'(launched[b+1]), 32'hB2);
            check("t6_gap", 32'(launch_cyc[b+1] - launch_cyc[b]), 32'd7);
        end
        tick(10);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
